// File: rtl/word_serializer.sv
// word_serializer
//   Accepts 32-bit words tagged with a byte count (1-4). It emits their bytes
//   on an 8-bit valid/ready egress port with no idle cycle between words.
//
//   Parameters
//     MSB_FIRST  0: byte 0 (w_data_i[7:0]) first; 1: byte 3 (w_data_i[31:24]) first
//   Macro
//     WORD_SER_LAST_EN  adds e_last_o, which marks the final byte of each word
//   Ports
//     clk, reset            clock, asynchronous active-high reset
//     w_valid_i/w_ready_o   word handshake (w_ready_o is combinational from
//                           e_ready_i only while the last byte is presented)
//     w_data_i, w_nbytes_i  word payload and byte count (0 and 5-7 mean 4)
//     e_valid_o/e_ready_i   byte handshake (e_valid_o is registered)
//     e_data_o              byte payload, 0 while e_valid_o is low
//     e_last_o              last byte of word (WORD_SER_LAST_EN only)
module word_serializer #(
  parameter int unsigned MSB_FIRST = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        w_valid_i,
  input  logic [31:0] w_data_i,
  input  logic [2:0]  w_nbytes_i,
  output logic        w_ready_o,
  input  logic        e_ready_i,
  output logic        e_valid_o,
  output logic [7:0]  e_data_o
`ifdef WORD_SER_LAST_EN
  ,
  output logic        e_last_o
`endif
);

  localparam int unsigned WORD_W = 32;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 3;
  localparam int unsigned IDX_W  = 2;

  // One-hot style encoding leaves unreachable codes that recover to IDLE
  typedef enum logic [1:0] {
    ST_IDLE = 2'b01,
    ST_SEND = 2'b10
  } state_e;

  state_e              state_q, state_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic [CNT_W-1:0]    rem_q, rem_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                e_valid_q, e_valid_d;
  logic [BYTE_W-1:0]   e_data_q, e_data_d;
  logic                load;
`ifdef WORD_SER_LAST_EN
  logic                e_last_q, e_last_d;
`endif

  // Byte counts outside 1..4 are sent as full words
  function automatic logic [CNT_W-1:0] norm_nbytes(input logic [2:0] n);
    if (n >= 3'd1 && n <= 3'd4) return CNT_W'(n);
    return CNT_W'(4);
  endfunction

  // Selects the byte for position idx in the configured transmit order
  function automatic logic [BYTE_W-1:0] pick_byte(input logic [WORD_W-1:0] w,
                                                  input logic [IDX_W-1:0]  idx);
    logic [IDX_W-1:0] sel;
    logic [BYTE_W-1:0] b;
    sel = (MSB_FIRST != 0) ? IDX_W'(2'd3 - idx) : idx;
    case (sel)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    return b;
  endfunction

  // Next-state logic; egress outputs are derived from the next state so they
  // are registered and hold steady while the downstream stalls
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    rem_d   = rem_q;
    idx_d   = idx_q;
    load    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (w_valid_i) load = 1'b1;
      end
      ST_SEND: begin
        if (e_ready_i) begin
          rem_d = CNT_W'(rem_q - CNT_W'(1));
          idx_d = IDX_W'(idx_q + IDX_W'(1));
          if (rem_q == CNT_W'(1)) begin
            if (w_valid_i) load = 1'b1;
            else           state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        word_d  = '0;
        rem_d   = '0;
        idx_d   = '0;
      end
    endcase

    if (load) begin
      state_d = ST_SEND;
      word_d  = w_data_i;
      rem_d   = norm_nbytes(w_nbytes_i);
      idx_d   = '0;
    end

    e_valid_d = (state_d == ST_SEND);
    e_data_d  = e_valid_d ? pick_byte(word_d, idx_d) : '0;
`ifdef WORD_SER_LAST_EN
    e_last_d  = e_valid_d && (rem_d == CNT_W'(1));
`endif
  end

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      word_q    <= '0;
      rem_q     <= '0;
      idx_q     <= '0;
      e_valid_q <= 1'b0;
      e_data_q  <= '0;
`ifdef WORD_SER_LAST_EN
      e_last_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      word_q    <= word_d;
      rem_q     <= rem_d;
      idx_q     <= idx_d;
      e_valid_q <= e_valid_d;
      e_data_q  <= e_data_d;
`ifdef WORD_SER_LAST_EN
      e_last_q  <= e_last_d;
`endif
    end
  end

  // Word ready: always in IDLE, pass-through of e_ready_i on the last byte
  always_comb begin
    w_ready_o = 1'b0;
    if (!reset) begin
      case (state_q)
        ST_IDLE: w_ready_o = 1'b1;
        ST_SEND: w_ready_o = (rem_q == CNT_W'(1)) ? e_ready_i : 1'b0;
        default: w_ready_o = 1'b0;
      endcase
    end
  end

  assign e_valid_o = e_valid_q;
  assign e_data_o  = e_data_q;
`ifdef WORD_SER_LAST_EN
  assign e_last_o  = e_last_q;
`endif

endmodule

// File: tb/tb_word_serializer.sv
module tb_word_serializer;

  logic        clk;
  logic        reset;
  logic        w_valid;
  logic [31:0] w_data;
  logic [2:0]  w_nbytes;
  logic        e_ready;
  logic        l_wready, m_wready;
  logic        l_valid, m_valid;
  logic [7:0]  l_data, m_data;
  logic        l_last, m_last;

  int n_cmp = 0;
  int n_err = 0;

  // Expected bytes: {last, data}
  logic [8:0] q_l[$];
  logic [8:0] q_m[$];

  word_serializer #(.MSB_FIRST(0)) dut_lsb (
    .clk(clk), .reset(reset),
    .w_valid_i(w_valid), .w_data_i(w_data), .w_nbytes_i(w_nbytes),
    .w_ready_o(l_wready), .e_ready_i(e_ready),
    .e_valid_o(l_valid), .e_data_o(l_data)
`ifdef WORD_SER_LAST_EN
    , .e_last_o(l_last)
`endif
  );

  word_serializer #(.MSB_FIRST(1)) dut_msb (
    .clk(clk), .reset(reset),
    .w_valid_i(w_valid), .w_data_i(w_data), .w_nbytes_i(w_nbytes),
    .w_ready_o(m_wready), .e_ready_i(e_ready),
    .e_valid_o(m_valid), .e_data_o(m_data)
`ifdef WORD_SER_LAST_EN
    , .e_last_o(m_last)
`endif
  );

`ifndef WORD_SER_LAST_EN
  assign l_last = 1'b0;
  assign m_last = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic int norm(input logic [2:0] n);
    if (n >= 3'd1 && n <= 3'd4) return int'(n);
    return 4;
  endfunction

  // Scoreboard: pushes on word handshake, pops on byte handshake
  always @(negedge clk) begin
    logic [8:0] e;
    int n;
    if (reset) begin
      q_l.delete();
      q_m.delete();
    end else begin
      if (!l_valid) chk("lsb_idle_data", 32'(l_data), 32'h0);
      if (!m_valid) chk("msb_idle_data", 32'(m_data), 32'h0);
      if (l_valid && e_ready) begin
        if (q_l.size() == 0) chk("lsb_unexpected_byte", 32'(l_data), 32'hFFFF_FFFF);
        else begin
          e = q_l.pop_front();
          chk("lsb_byte", 32'(l_data), 32'(e[7:0]));
`ifdef WORD_SER_LAST_EN
          chk("lsb_last", 32'(l_last), 32'(e[8]));
`endif
        end
      end
      if (m_valid && e_ready) begin
        if (q_m.size() == 0) chk("msb_unexpected_byte", 32'(m_data), 32'hFFFF_FFFF);
        else begin
          e = q_m.pop_front();
          chk("msb_byte", 32'(m_data), 32'(e[7:0]));
`ifdef WORD_SER_LAST_EN
          chk("msb_last", 32'(m_last), 32'(e[8]));
`endif
        end
      end
      if (w_valid && l_wready) begin
        n = norm(w_nbytes);
        for (int i = 0; i < n; i++) begin
          q_l.push_back({(i == n - 1), w_data[8*i +: 8]});
          q_m.push_back({(i == n - 1), w_data[8*(3-i) +: 8]});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] exp4 [4];
    logic [7:0] bb   [5];
    logic [7:0] bbm  [5];
    logic       acc;
    int         budget;

    reset = 1'b1; w_valid = 1'b0; w_data = '0; w_nbytes = '0; e_ready = 1'b1;
    #3;
    chk("rst_wready", 32'(l_wready), 32'h0);
    chk("rst_valid", 32'(l_valid), 32'h0);
    chk("rst_data", 32'(l_data), 32'h0);
    #9 reset = 1'b0;
    tick;
    chk("post_rst_wready", 32'(l_wready), 32'h1);
    chk("post_rst_valid", 32'(l_valid), 32'h0);

    // Single 4-byte word, LSB first
    exp4[0] = 8'hAA; exp4[1] = 8'hBB; exp4[2] = 8'hCC; exp4[3] = 8'hDD;
    w_valid = 1'b1; w_data = 32'hDDCCBBAA; w_nbytes = 3'd4;
    tick;
    w_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("t1_valid", 32'(l_valid), 32'h1);
      chk("t1_data", 32'(l_data), 32'(exp4[i]));
      chk("t1_msb_data", 32'(m_data), 32'(exp4[3-i]));
      chk("t1_wready", 32'(l_wready), 32'(i == 3));
`ifdef WORD_SER_LAST_EN
      chk("t1_last", 32'(l_last), 32'(i == 3));
`endif
      tick;
    end
    chk("t1_idle_valid", 32'(l_valid), 32'h0);
    chk("t1_idle_wready", 32'(l_wready), 32'h1);

    // Single-byte word
    w_valid = 1'b1; w_data = 32'h12345678; w_nbytes = 3'd1;
    tick;
    w_valid = 1'b0;
    chk("t2_data", 32'(l_data), 32'h78);
    chk("t2_msb_data", 32'(m_data), 32'h12);
    chk("t2_wready", 32'(l_wready), 32'h1);
    tick;
    chk("t2_idle", 32'(l_valid), 32'h0);

    // nbytes = 0 sends a full word
    w_valid = 1'b1; w_data = 32'h11223344; w_nbytes = 3'd0;
    tick;
    w_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("t2n0_valid", 32'(l_valid), 32'h1);
      tick;
    end
    chk("t2n0_idle", 32'(l_valid), 32'h0);

    // Back-to-back words with w_valid held high
    bb[0] = 8'h01; bb[1] = 8'h02; bb[2] = 8'h0D; bb[3] = 8'h0C; bb[4] = 8'h0B;
    bbm[0] = 8'h04; bbm[1] = 8'h03; bbm[2] = 8'h0A; bbm[3] = 8'h0B; bbm[4] = 8'h0C;
    w_valid = 1'b1; w_data = 32'h04030201; w_nbytes = 3'd2;
    tick;
    w_data = 32'h0A0B0C0D; w_nbytes = 3'd3;
    for (int i = 0; i < 5; i++) begin
      chk("t3_valid", 32'(l_valid), 32'h1);
      chk("t3_data", 32'(l_data), 32'(bb[i]));
      chk("t3_msb_data", 32'(m_data), 32'(bbm[i]));
      if (i < 4) chk("t3_wready", 32'(l_wready), 32'(i == 1));
      if (i == 2) w_valid = 1'b0;
      tick;
    end
    chk("t3_idle", 32'(l_valid), 32'h0);

    // Backpressure on the second byte
    w_valid = 1'b1; w_data = 32'hDDCCBBAA; w_nbytes = 3'd4;
    tick;
    w_valid = 1'b0;
    chk("t4_first", 32'(l_data), 32'hAA);
    tick;
    e_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("t4_hold_valid", 32'(l_valid), 32'h1);
      chk("t4_hold_data", 32'(l_data), 32'hBB);
      chk("t4_hold_wready", 32'(l_wready), 32'h0);
      tick;
    end
    e_ready = 1'b1;
    chk("t4_release_data", 32'(l_data), 32'hBB);
    tick;
    chk("t4_cc", 32'(l_data), 32'hCC);
    tick;
    chk("t4_dd", 32'(l_data), 32'hDD);
    tick;
    chk("t4_idle", 32'(l_valid), 32'h0);

    // Two-byte word: MSB instance sends DD, CC
    w_valid = 1'b1; w_data = 32'hDDCCBBAA; w_nbytes = 3'd2;
    tick;
    w_valid = 1'b0;
    chk("t5_msb_b0", 32'(m_data), 32'hDD);
    tick;
    chk("t5_msb_b1", 32'(m_data), 32'hCC);
    tick;
    chk("t5_msb_idle", 32'(m_valid), 32'h0);

    // Reset in the middle of a word
    w_valid = 1'b1; w_data = 32'hDDCCBBAA; w_nbytes = 3'd4;
    tick;
    w_valid = 1'b0;
    tick;
    tick;
    chk("t6_pre_rst_data", 32'(l_data), 32'hCC);
    #2 reset = 1'b1;
    #1;
    chk("t6_async_valid", 32'(l_valid), 32'h0);
    chk("t6_async_data", 32'(l_data), 32'h0);
    chk("t6_async_wready", 32'(l_wready), 32'h0);
    @(posedge clk);
    #2 reset = 1'b0;
    tick;
    chk("t6_post_wready", 32'(l_wready), 32'h1);
    for (int i = 0; i < 3; i++) begin
      chk("t6_no_residual", 32'(l_valid), 32'h0);
      tick;
    end

    // Random words with random downstream stalls
    for (int k = 0; k < 40; k++) begin
      w_valid = 1'b1;
      w_data = $urandom;
      w_nbytes = 3'($urandom_range(0, 7));
      budget = 0;
      do begin
        e_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        acc = l_wready;
        @(posedge clk);
        #1;
        budget++;
      end while (!acc && budget < 100);
      if (!acc) chk("rand_accept_timeout", 32'(budget), 32'h0);
      w_valid = ($urandom_range(0, 3) != 0);
      if (!w_valid) begin
        e_ready = 1'($urandom_range(0, 1));
        tick;
      end
    end
    w_valid = 1'b0;
    e_ready = 1'b1;
    budget = 0;
    while (q_l.size() != 0 && budget < 50) begin
      tick;
      budget++;
    end
    chk("drain_empty", 32'(q_l.size()), 32'h0);
    tick;
    chk("drain_idle", 32'(l_valid), 32'h0);
    chk("drain_msb_empty", 32'(q_m.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
